regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the ARM datapath; successor to the single-write, two-read file.

---
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, NRD packed read ports, PC input and status flags.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NRD    = 3
);
  logic                    we3;
  logic [ADDR_W-1:0]       a3;
  logic [DATA_W-1:0]       wd3;
  logic                    we4;
  logic [ADDR_W-1:0]       a4;
  logic [DATA_W-1:0]       wd4;
  logic [NRD*ADDR_W-1:0]   ra;
  logic [DATA_W-1:0]       r15;
  logic [NRD*DATA_W-1:0]   rd;
  logic                    init_done;
  logic                    wr_conflict;

  modport master (
    output we3, a3, wd3, we4, a4, wd4, ra, r15,
    input  rd, init_done, wr_conflict
  );

  modport slave (
    input  we3, a3, wd3, we4, a4, wd4, ra, r15,
    output rd, init_done, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port ARM register file: NRD async reads, two sync writes, PC pseudo-register, post-reset clear.
// Optional write-first read bypass is compiled in with `define RF_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREGS  = 15,
  parameter int unsigned NRD    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);

  typedef enum logic {CLEAR, RUN} state_e;

  localparam logic [ADDR_W-1:0] PC_ADDR  = '1;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] NREGS_A  = ADDR_W'(NREGS);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              init_done_q;
  logic              wr_conflict_q;
  logic              wr_conflict_d;
  logic              wr3_en;
  logic              wr4_en;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [NRD*DATA_W-1:0] rd_d;

  assign wr3_en        = (state_q == RUN) && bus.we3 && (bus.a3 < NREGS_A);
  assign wr4_en        = (state_q == RUN) && bus.we4 && (bus.a4 < NREGS_A);
  assign wr_conflict_d = wr3_en && wr4_en && (bus.a3 == bus.a4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLEAR;
      clr_ptr_q     <= '0;
      init_done_q   <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= wr_conflict_d;
      case (state_q)
        CLEAR: begin
          if (clr_ptr_q == LAST_REG) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
            clr_ptr_q   <= '0;
          end else begin
            clr_ptr_q   <= clr_ptr_q + 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  // Storage has no reset; the clear sequencer zeroes it. Port 4 is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      rf_q[clr_ptr_q] <= '0;
    end else begin
      if (wr3_en) rf_q[bus.a3] <= bus.wd3;
      if (wr4_en) rf_q[bus.a4] <= bus.wd4;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (a == PC_ADDR) return bus.r15;
    if ((state_q != RUN) || (a >= NREGS_A)) return '0;
`ifdef RF_BYPASS_EN
    // a is already known mapped, so an address match implies a valid write.
    if (bus.we4 && (bus.a4 == a)) return bus.wd4;
    if (bus.we3 && (bus.a3 == a)) return bus.wd3;
`endif
    return rf_q[a];
  endfunction

  always_comb begin
    rd_d = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_d[k*DATA_W +: DATA_W] = read_port(bus.ra[k*ADDR_W +: ADDR_W]);
    end
  end

  assign bus.rd          = rd_d;
  assign bus.init_done   = init_done_q;
  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp with hand sequences for clear, reset and bypass timing.
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned passed;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NRD(3)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NREGS(15), .NRD(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we3;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic        we4;
    logic [3:0]  a4;
    logic [31:0] wd4;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] r15;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        econf;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    bus.ra = {r2, r1, r0};
  endtask

  task automatic idle_writes();
    bus.we3 = 1'b0; bus.a3 = '0; bus.wd3 = '0;
    bus.we4 = 1'b0; bus.a4 = '0; bus.wd4 = '0;
  endtask

  task automatic wait_init(input string name);
    int unsigned n;
    n = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      tick();
      n = i;
      if (bus.init_done) break;
    end
    if (!bus.init_done) n = 99;
    check(name, n, 32'd15);
  endtask

  task automatic apply(input vec_t v, input int idx);
    bus.we3 = v.we3; bus.a3 = v.a3; bus.wd3 = v.wd3;
    bus.we4 = v.we4; bus.a4 = v.a4; bus.wd4 = v.wd4;
    set_ra(v.ra0, v.ra1, v.ra2);
    bus.r15 = v.r15;
    #4;
    check($sformatf("v%0d_rd0", idx), bus.rd[31:0],  v.e0);
    check($sformatf("v%0d_rd1", idx), bus.rd[63:32], v.e1);
    check($sformatf("v%0d_rd2", idx), bus.rd[95:64], v.e2);
    check($sformatf("v%0d_conf", idx), {31'd0, bus.wr_conflict}, {31'd0, v.econf});
    tick();
  endtask

  initial begin
    logic [31:0] exp_b;
    total  = 0;
    passed = 0;

    //            we3   a3  wd3            we4   a4  wd4            ra0 ra1 ra2 r15           e0             e1            e2             conf
    vt[0]  = '{1'b1, 4'd5,  32'h1234_5678, 1'b0, 4'd0,  32'h0,         4'd1, 4'd15, 4'd2,  32'h0000_0108, 32'h0,         32'h0000_0108, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         4'd5, 4'd15, 4'd14, 32'h0000_010C, 32'h1234_5678, 32'h0000_010C, 32'h0,         1'b0};
    vt[2]  = '{1'b1, 4'd7,  32'h11,        1'b1, 4'd7,  32'h22,        4'd5, 4'd15, 4'd0,  32'h0000_010C, 32'h1234_5678, 32'h0000_010C, 32'h0,         1'b0};
    vt[3]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         4'd7, 4'd15, 4'd5,  32'h0000_0110, 32'h22,        32'h0000_0110, 32'h1234_5678, 1'b1};
    vt[4]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd14, 32'hCAFE_0014, 4'd7, 4'd15, 4'd0,  32'h0000_0110, 32'h22,        32'h0000_0110, 32'h0,         1'b0};
    vt[5]  = '{1'b1, 4'd15, 32'hDEAD_BEEF, 1'b1, 4'd15, 32'h5555,      4'd14, 4'd15, 4'd7, 32'h0000_0114, 32'hCAFE_0014, 32'h0000_0114, 32'h22,        1'b0};
    vt[6]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         4'd14, 4'd15, 4'd13, 32'h0000_0200, 32'hCAFE_0014, 32'h0000_0200, 32'h0,        1'b0};
    vt[7]  = '{1'b1, 4'd1,  32'hA1,        1'b1, 4'd2,  32'hB2,        4'd14, 4'd15, 4'd0, 32'h0000_0200, 32'hCAFE_0014, 32'h0000_0200, 32'h0,         1'b0};
    vt[8]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         4'd1, 4'd2,  4'd0,  32'h0000_0204, 32'hA1,        32'hB2,        32'h0,         1'b0};
    vt[9]  = '{1'b1, 4'd3,  32'h55,        1'b0, 4'd0,  32'h0,         4'd1, 4'd2,  4'd14, 32'h0000_0204, 32'hA1,        32'hB2,        32'hCAFE_0014, 1'b0};
    vt[10] = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         4'd3, 4'd15, 4'd0,  32'h0000_0208, 32'h55,        32'h0000_0208, 32'h0,         1'b0};

    // Reset and clear with a write held on port 3 the whole time
    rst_n   = 1'b0;
    bus.we3 = 1'b1; bus.a3 = 4'd2; bus.wd3 = 32'hAAAA_AAAA;
    bus.we4 = 1'b0; bus.a4 = '0;   bus.wd4 = '0;
    bus.r15 = 32'h0000_0108;
    set_ra(4'd15, 4'd2, 4'd0);
    #2;
    check("rst_init_done",   {31'd0, bus.init_done},   32'd0);
    check("rst_wr_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    check("rst_rd_pc",       bus.rd[31:0],  32'h0000_0108);
    check("rst_rd_r2",       bus.rd[63:32], 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("clear_rd_r2", bus.rd[63:32], 32'h0);
    wait_init("init_cycles_1");
    idle_writes();
    #1;
    check("after_clear_r2", bus.rd[63:32], 32'h0);
    check("after_clear_pc", bus.rd[31:0],  32'h0000_0108);
    #3;
    tick();

    for (int i = 0; i < 11; i++) apply(vt[i], i);

    // Conflict flag must be cleared by an asynchronous reset, and the reset re-clears storage
    bus.we3 = 1'b1; bus.a3 = 4'd9; bus.wd3 = 32'h91;
    bus.we4 = 1'b1; bus.a4 = 4'd9; bus.wd4 = 32'h92;
    tick();
    idle_writes();
    check("conf_pre_reset", {31'd0, bus.wr_conflict}, 32'd1);
    set_ra(4'd3, 4'd15, 4'd9);
    bus.r15 = 32'h0000_0300;
    #1;
    check("pre_reset_r3", bus.rd[31:0], 32'h55);
    rst_n = 1'b0;
    #1;
    check("midrun_init_done",   {31'd0, bus.init_done},   32'd0);
    check("midrun_wr_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    check("midrun_rd_r3",       bus.rd[31:0],  32'h0);
    check("midrun_rd_pc",       bus.rd[63:32], 32'h0000_0300);
    tick();
    rst_n = 1'b1;
    wait_init("init_cycles_2");
    #1;
    check("reclear_r3", bus.rd[31:0],  32'h0);
    check("reclear_r9", bus.rd[95:64], 32'h0);
    #3;
    tick();

    // Same-cycle read of a register being written
    bus.we3 = 1'b1; bus.a3 = 4'd4; bus.wd3 = 32'h10;
    tick();
    bus.wd3 = 32'h99;
    set_ra(4'd4, 4'd15, 4'd0);
`ifdef RF_BYPASS_EN
    exp_b = 32'h99;
`else
    exp_b = 32'h10;
`endif
    #4;
    check("same_cycle_r4", bus.rd[31:0], exp_b);
    tick();
    idle_writes();
    #4;
    check("next_cycle_r4", bus.rd[31:0], 32'h99);
    tick();

    // Both ports to one register: port 4 data visible early only with bypass
    bus.we3 = 1'b1; bus.a3 = 4'd8; bus.wd3 = 32'h33;
    bus.we4 = 1'b1; bus.a4 = 4'd8; bus.wd4 = 32'h44;
    set_ra(4'd8, 4'd15, 4'd0);
`ifdef RF_BYPASS_EN
    exp_b = 32'h44;
`else
    exp_b = 32'h0;
`endif
    #4;
    check("same_cycle_r8", bus.rd[31:0], exp_b);
    tick();
    idle_writes();
    #4;
    check("next_cycle_r8",  bus.rd[31:0], 32'h44);
    check("conf_r8",        {31'd0, bus.wr_conflict}, 32'd1);
    tick();
    check("conf_r8_clears", {31'd0, bus.wr_conflict}, 32'd0);

    // The PC address is never bypassed
    bus.we3 = 1'b1; bus.a3 = 4'd15; bus.wd3 = 32'hDEAD_BEEF;
    bus.r15 = 32'h0000_0400;
    set_ra(4'd15, 4'd8, 4'd0);
    #4;
    check("pc_no_bypass", bus.rd[31:0],  32'h0000_0400);
    check("pc_write_r8",  bus.rd[63:32], 32'h44);
    tick();
    idle_writes();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
